lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Load/store initiator that drives the word-organised data memory port (ren/wen/addr/size/wdata/rdata, one-cycle registered read) on behalf of the CPU pipeline.
- Accepts one load or store at a time over a valid/ready request channel.
- Issues only full-word memory accesses. Byte and halfword stores are done as read-modify-write so neighbouring lanes are preserved.
- Load data is lane-extracted and sign/zero-extended locally.
- Returns a single-cycle response with data or a fault flag.

## Interface
Parameters:
- ADDR_W, 14, byte-address width of the memory port (16 KiB window)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE and not in reset
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response strobe (no backpressure)
- resp_fault  out  1  valid with resp_valid; request rejected, no memory access
- resp_rdata  out  32  load result; 0 for stores and faults
- mem_ren  out  1  memory read enable
- mem_wen  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned byte address, bits [1:0] always 00
- mem_size  out  2  constant 2'b10 (word)
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  memory read data, valid the cycle after mem_ren is sampled

## Operation
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. All request fields are latched at that edge. Inputs are ignored in every other state.
- Fault checks, evaluated at accept:
  - size 11;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[31:ADDR_W]≠0.
  A faulting request goes to RESP with resp_fault=1 and issues no memory strobe.
- States: IDLE, RD, WAIT, WR, RESP.
  - IDLE → RD: load or sub-word store.
  - IDLE → WR: word store.
  - IDLE → RESP: fault.
  - RD → WAIT, unconditional.
  - WAIT → RESP: load. Extract lane from mem_rdata and extend into the result register.
  - WAIT → WR: sub-word store. Merge into the captured word. Byte lane = addr[1:0], bits [8k+7:8k]. Halfword lane = addr[1], bits [16h+15:16h].
  - WR → RESP, unconditional.
  - RESP → IDLE, unconditional.
- Memory strobes are decoded from the registered state:
  - mem_ren = (state==RD);
  - mem_wen = (state==WR);
  - mem_ren and mem_wen are never both high.
- mem_addr = {addr[ADDR_W-1:2], 2'b00} from the latched address. It is held stable through RD/WAIT/WR.
- mem_wdata is driven as follows:
  - word store: req_wdata;
  - sub-word store: merged word;
  - otherwise 0.
- Extension:
  - byte signed: {{24{b[7]}}, b};
  - halfword signed: {{16{h[15]}}, h};
  - unsigned variants zero-fill;
  - word loads pass through unchanged.
- resp_rdata and resp_fault are registered and valid only while resp_valid=1. Outside RESP they are 0.

## Timing
- Accept edge = T. Latency to resp_valid:
  - fault: T+1;
  - word store: mem_wen in T+1, resp in T+2;
  - load: mem_ren in T+1, data captured at end of T+2, resp in T+3;
  - sub-word store: mem_ren T+1, merge T+2, mem_wen T+3, resp T+4.
- resp_valid is high for exactly one cycle.
- req_ready rises the cycle after RESP. The minimum spacing between accepts is therefore latency+1 cycles.
- Reset values: state=IDLE. resp_valid, resp_fault, resp_rdata, mem_ren, mem_wen, mem_addr and mem_wdata are all 0. mem_size is 10. req_ready is 0 while reset=1.
- Reset mid-operation: the transaction is dropped and no response is produced.
  - Reset sampled in RD or WAIT: no write is ever issued, so memory is unchanged.
  - Reset sampled in WR: the memory also samples mem_wen=1 at that edge, so the write completes.
- req_valid held high across a response is not re-accepted until IDLE.

## Test plan
- Word store 0xDEADBEEF @0x0100, then word load @0x0100. Expect mem_wen in T+1, resp T+2 with fault 0 and rdata 0. The load responds at T+3 with rdata 0xDEADBEEF.
- Preload @0x0200 = 0x11223344. Byte store 0xAA @0x0202. Expect the RMW sequence ren, wait, wen with mem_wdata 0x11AA3344, resp at T+4. A word load then returns 0x11AA3344.
- Load from 0x11AA3344 @0x0200:
  - signed byte @0x0202 → 0xFFFFFFAA;
  - unsigned byte @0x0202 → 0x000000AA;
  - signed halfword @0x0202 → 0x000011AA.
- Faults: each must give resp T+1, fault 1, rdata 0, and no ren/wen.
  - halfword @0x0101;
  - word @0x0102;
  - size 11;
  - addr 0x00004000.
- Reset asserted during WAIT of a sub-word store to 0x0200. Expect no mem_wen, no resp_valid, and the word still reads 0x11223344. req_ready returns the cycle after reset deasserts.
- Back-to-back: req_valid held high with 3 queued word loads. Expect accepts at T, T+4, T+8, with no accept while req_ready=0 and exactly one resp per request.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-organised data memory with a one-cycle registered read.
// Sub-word stores are read-modify-write; load lanes are extracted and extended locally.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  // Request channel: a request is taken on a rising edge where req_valid && req_ready.
  // req_ready is high only in IDLE outside reset; responses have no backpressure.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_fault,
  output logic [31:0]       resp_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t             state;
  logic               wr_q;
  logic [1:0]         size_q;
  logic               signed_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        wdata_q;

  logic               req_fault;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        load_word;
  logic [31:0]        merged_word;

  assign req_ready = (state == IDLE) && !reset;
  assign mem_ren   = (state == RD);
  assign mem_wen   = (state == WR);
  assign mem_size  = 2'b10;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    req_fault = (req_size == 2'b11)
             || (req_size == 2'b01 && req_addr[0])
             || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
             || (req_addr[31:ADDR_W] != '0);
  end

  // Lane extraction for loads and lane merge for sub-word stores share the latched offset.
  always_comb begin
    rd_byte     = 8'h00;
    rd_half     = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_word   = mem_rdata;
    merged_word = mem_rdata;
    case (addr_q[1:0])
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    case (size_q)
      2'b00: begin
        load_word = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
        case (addr_q[1:0])
          2'd0:    merged_word[7:0]   = wdata_q[7:0];
          2'd1:    merged_word[15:8]  = wdata_q[7:0];
          2'd2:    merged_word[23:16] = wdata_q[7:0];
          default: merged_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        load_word = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
        if (addr_q[1]) merged_word[31:16] = wdata_q;
        else           merged_word[15:0]  = wdata_q;
      end
      default: load_word = mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 16'h0;
      mem_wdata  <= 32'h0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q     <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr[ADDR_W-1:0];
            wdata_q  <= req_wdata[15:0];
            if (req_fault) begin
              state      <= RESP;
              mem_wdata  <= 32'h0;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_write && req_size == 2'b10) begin
              state     <= WR;
              mem_wdata <= req_wdata;
            end else begin
              state     <= RD;
              mem_wdata <= 32'h0;
            end
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          if (wr_q) begin
            state     <= WR;
            mem_wdata <= merged_word;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= load_word;
          end
        end
        WR: begin
          state      <= RESP;
          mem_wdata  <= 32'h0;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= 32'h0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
